// File: rtl/multicycle_controller.sv
// multicycle_controller: sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port
// with a req/ack handshake, decoding the 6-bit opcode map into datapath strobes/selects.
// Optional feature: define OVF_TRAP_EN to trap on overflow for ops 0,1,6,7,15 in EXEC.
module multicycle_controller #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [5:0]       opcode,
  input  logic             branch_taken,
  input  logic             overflow,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic [1:0]       mem_size,
  output logic             mem_sel_instr,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_src,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  state_e           state_q, state_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [CNT_W-1:0] count_q;
  logic             trap_q;
  logic [1:0]       cause_q, cause_d;
  logic             retire;
  logic             tmo_hit;

  // Opcode classes
  logic op_alu, op_load, op_lui, op_mul, op_store, op_branch, op_j, op_jal, op_jr;
  logic op_illegal, op_rd_dst, ovf_trap;
  logic [5:0] size_ld, size_st;

  assign op_alu     = (opcode <= 6'd10);
  assign op_load    = (opcode >= 6'd11) && (opcode <= 6'd13);
  assign op_lui     = (opcode == 6'd14);
  assign op_mul     = (opcode == 6'd15);
  assign op_store   = (opcode >= 6'd16) && (opcode <= 6'd18);
  assign op_branch  = (opcode >= 6'd19) && (opcode <= 6'd21);
  assign op_j       = (opcode == 6'd22);
  assign op_jal     = (opcode == 6'd23);
  assign op_jr      = (opcode == 6'd24);
  assign op_illegal = (opcode > 6'd24);
  // R-type ALU and mul write rd; everything else that writes back uses rt
  assign op_rd_dst  = (opcode <= 6'd5) || op_mul;
  assign size_ld    = opcode - 6'd11;
  assign size_st    = opcode - 6'd16;

`ifdef OVF_TRAP_EN
  assign ovf_trap = overflow && ((opcode == 6'd0) || (opcode == 6'd1) || (opcode == 6'd6) ||
                                 (opcode == 6'd7) || (opcode == 6'd15));
`else
  // Overflow is deliberately ignored in this build
  assign ovf_trap = overflow & 1'b0;
`endif

  // A waiting request has used up its budget when this is its TIMEOUT-th unacked cycle
  assign tmo_hit = !mem_ack && (tmo_q == TmoW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, retire and timeout-counter logic
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    cause_d = 2'd0;
    retire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !halt_req) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          state_d = StDecode;
        end else if (tmo_hit) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDecode: begin
        if (op_illegal) begin
          state_d = StTrap;
          cause_d = 2'd1;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        if (ovf_trap) begin
          state_d = StTrap;
          cause_d = 2'd3;
        end else if (op_alu || op_lui || op_mul) begin
          state_d = StWb;
        end else if (op_load || op_store) begin
          state_d = StMem;
        end else begin
          retire = 1'b1;
        end
      end
      StMem: begin
        if (mem_ack) begin
          if (op_load) state_d = StWb;
          else         retire  = 1'b1;
        end else if (tmo_hit) begin
          state_d = StTrap;
          cause_d = 2'd2;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StWb: begin
        retire = 1'b1;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Instruction boundary: halt is honoured only here
    if (retire) state_d = halt_req ? StIdle : StFetch;
  end

  // Timeout counter, retired-instruction counter and sticky trap status
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q   <= '0;
      count_q <= '0;
      trap_q  <= 1'b0;
      cause_q <= 2'd0;
    end else begin
      tmo_q <= tmo_d;
      if (retire) count_q <= count_q + CNT_W'(1);
      if ((state_d == StTrap) && (state_q != StTrap)) begin
        trap_q  <= 1'b1;
        cause_q <= cause_d;
      end
    end
  end

  // Strobe and select decode from the current state
  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_size      = 2'd0;
    mem_sel_instr = 1'b0;
    ir_we         = 1'b0;
    pc_we         = 1'b0;
    pc_src        = 2'd0;
    reg_we        = 1'b0;
    reg_dst       = 2'd0;
    wb_src        = 2'd0;
    unique case (state_q)
      StFetch: begin
        mem_req       = 1'b1;
        mem_size      = 2'd2;
        mem_sel_instr = 1'b1;
        if (mem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      StExec: begin
        if (op_branch) begin
          pc_we  = branch_taken;
          pc_src = 2'd1;
        end else if (op_j) begin
          pc_we  = 1'b1;
          pc_src = 2'd2;
        end else if (op_jal) begin
          pc_we   = 1'b1;
          pc_src  = 2'd2;
          reg_we  = 1'b1;
          reg_dst = 2'd2;
          wb_src  = 2'd2;
        end else if (op_jr) begin
          pc_we  = 1'b1;
          pc_src = 2'd3;
        end
      end
      StMem: begin
        mem_req  = 1'b1;
        mem_we   = op_store;
        mem_size = op_store ? size_st[1:0] : size_ld[1:0];
      end
      StWb: begin
        reg_we  = 1'b1;
        reg_dst = op_rd_dst ? 2'd0 : 2'd1;
        if (op_load)     wb_src = 2'd1;
        else if (op_lui) wb_src = 2'd3;
        else             wb_src = 2'd0;
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != StIdle) && (state_q != StTrap);
  assign trap        = trap_q;
  assign trap_cause  = cause_q;
  assign instr_count = count_q;

endmodule
